pcie_io_buf: RTL and testbench
==============================

PCIE_IO_BUF -- requirements
Module: pcie_io_buf

Interface
REQ-001 Parameter REFCLK_HROW_CK_SEL, default 2'b00, SHALL select the ODIV2 mode (00 = O, 01 = O/2, 10 = 0, 11 = 0).
REQ-002 sys_clk_p  input  1  positive leg of the differential PCIe reference clock; this pair is the block's one clock.
REQ-003 sys_clk_n  input  1  negative leg of the reference clock.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 ceb  input  1  active-low clock enable for the reference-clock buffer.
REQ-006 sys_rst_n  input  1  board reset pad (active-low), passed through the input buffer.
REQ-007 leds  input  4  internal LED drive.
REQ-008 sys_clk_gt  output  1  buffered reference clock (O path, GT reference).
REQ-009 sys_clk  output  1  ODIV2 path, shaped per REFCLK_HROW_CK_SEL.
REQ-010 sys_rst_n_c  output  1  buffered board reset.
REQ-011 led_0, led_1, led_2, led_3  output  1 each  buffered LED pins.

Function
REQ-012 Differential resolve SHALL work as follows: p=1, n=0 gives 1; p=0, n=1 gives 0; p==n holds the last resolved value (initial value 0).
REQ-013 sys_clk_gt SHALL equal the resolved clock when ceb=0, and 0 when ceb=1.
REQ-014 ceb gating SHALL be combinational, with zero delay.
REQ-015 sys_clk_gt SHALL NOT be affected by sys_rst.
REQ-016 Mode 00: sys_clk SHALL equal sys_clk_gt, combinationally.
REQ-017 Mode 01: sys_clk SHALL come from a divide-by-2 flop that toggles on each rising edge of sys_clk_gt; the first rising edge after reset release drives sys_clk to 1.
REQ-018 Mode 01: while ceb=1 there are no edges, so the divider SHALL hold its state.
REQ-019 Modes 10 and 11: sys_clk SHALL be constant 0.
REQ-020 sys_rst=1 SHALL asynchronously clear the divider flop to 0 and force sys_clk to 0 in all modes.
REQ-021 When sys_rst deasserts, sys_clk SHALL resume per mode: immediately in mode 00; at the next rising edge in mode 01.
REQ-022 sys_rst_n_c SHALL equal sys_rst_n combinationally (IBUF), independent of clock, reset and ceb.
REQ-023 led_k SHALL equal leds[k] for k = 0..3 combinationally (OBUF), independent of clock, reset and ceb.
REQ-024 The block SHALL contain no other state and add no latency beyond the divider flop.
REQ-025 Implementation SHALL be behavioural (no vendor primitives), so that the same RTL simulates and synthesizes as a model of IBUFDS_GTE3 + IBUF + OBUF.

Reset
REQ-026 At time 0 and during sys_rst=1, the outputs SHALL be:
- sys_clk = 0
- divider = 0
- sys_clk_gt follows the clock per REQ-013
- sys_rst_n_c = sys_rst_n
- led_k = leds[k]
REQ-027 Reset assertion mid-cycle in mode 01 SHALL drop sys_clk to 0 within the same delta, without waiting for a clock edge.

Verification
REQ-028 Mode 00, ceb=0, sys_rst=0, 100 MHz clock on p/n -> sys_clk_gt and sys_clk both 100 MHz, in phase, with identical edges.
REQ-029 Mode 01, 100 MHz clock, release sys_rst -> sys_clk 50 MHz, 50% duty; first high at the first sys_clk_gt rising edge after release.
REQ-030 Mode 01, assert sys_rst while sys_clk=1 -> sys_clk=0 immediately; deassert -> toggling restarts from 0.
REQ-031 Any mode, ceb=1 for 10 cycles -> sys_clk_gt=0 and sys_clk=0 (mode 00) or held (mode 01); ceb=0 -> resumes with no glitch.
REQ-032 Drive p=n=1 after p=1/n=0 -> sys_clk_gt holds 1; then p=0/n=1 -> sys_clk_gt=0.
REQ-033 sys_rst_n: 0->1 -> sys_rst_n_c 0->1 same delta; leds = 4'b1010 -> led_3..led_0 = 1,0,1,0; both unaffected by sys_rst and ceb.

Source files
------------

// File: rtl/pcie_io_buf.sv
// Behavioural model of the PCIe reference-clock input buffer (differential resolve,
// ceb gating, optional divide-by-2 on the ODIV2 path) plus the reset IBUF and LED OBUFs.
module pcie_io_buf #(
    parameter logic [1:0] REFCLK_HROW_CK_SEL = 2'b00
) (
    input  logic       sys_clk_p,
    input  logic       sys_clk_n,
    input  logic       sys_rst,
    input  logic       ceb,
    input  logic       sys_rst_n,
    input  logic [3:0] leds,
    output logic       sys_clk_gt,
    output logic       sys_clk,
    output logic       sys_rst_n_c,
    output logic       led_0,
    output logic       led_1,
    output logic       led_2,
    output logic       led_3
);

    logic resolved;
    logic div_q;

    // A differential receiver keeps its last decision while both legs sit at
    // the same level, so this is deliberately a transparent latch.
    always_latch begin
        if (sys_clk_p ^ sys_clk_n)
            resolved <= sys_clk_p;
    end

    assign sys_clk_gt = resolved & ~ceb;

    always_ff @(posedge sys_clk_gt or posedge sys_rst) begin
        if (sys_rst)
            div_q <= 1'b0;
        else
            div_q <= ~div_q;
    end

    always_comb begin
        sys_clk = 1'b0;
        if (!sys_rst) begin
            case (REFCLK_HROW_CK_SEL)
                2'b00:   sys_clk = sys_clk_gt;
                2'b01:   sys_clk = div_q;
                default: sys_clk = 1'b0;
            endcase
        end
    end

    assign sys_rst_n_c = sys_rst_n;
    assign led_0       = leds[0];
    assign led_1       = leds[1];
    assign led_2       = leds[2];
    assign led_3       = leds[3];

endmodule

// File: tb/tb_pcie_io_buf.sv
// Directed bench for pcie_io_buf: one instance per ODIV2 mode (00, 01, 10)
// sharing all inputs, checked against hand-derived expectations.
module tb_pcie_io_buf;

    logic       p = 1'b0;
    logic       n = 1'b1;
    logic       run_clk = 1'b1;
    logic       rst;
    logic       ceb;
    logic       rst_n;
    logic [3:0] leds;

    logic [2:0] gt;
    logic [2:0] clk;
    logic [2:0] rstc;
    logic [3:0] led0, led1, led2;

    int checks = 0;
    int errors = 0;
    logic div;

    // 100 MHz reference clock on the differential pair
    always #5 begin
        if (run_clk) begin
            p = ~p;
            n = ~n;
        end
    end

    pcie_io_buf #(.REFCLK_HROW_CK_SEL(2'b00)) dut0 (
        .sys_clk_p(p), .sys_clk_n(n), .sys_rst(rst), .ceb(ceb), .sys_rst_n(rst_n), .leds(leds),
        .sys_clk_gt(gt[0]), .sys_clk(clk[0]), .sys_rst_n_c(rstc[0]),
        .led_0(led0[0]), .led_1(led0[1]), .led_2(led0[2]), .led_3(led0[3]));

    pcie_io_buf #(.REFCLK_HROW_CK_SEL(2'b01)) dut1 (
        .sys_clk_p(p), .sys_clk_n(n), .sys_rst(rst), .ceb(ceb), .sys_rst_n(rst_n), .leds(leds),
        .sys_clk_gt(gt[1]), .sys_clk(clk[1]), .sys_rst_n_c(rstc[1]),
        .led_0(led1[0]), .led_1(led1[1]), .led_2(led1[2]), .led_3(led1[3]));

    pcie_io_buf #(.REFCLK_HROW_CK_SEL(2'b10)) dut2 (
        .sys_clk_p(p), .sys_clk_n(n), .sys_rst(rst), .ceb(ceb), .sys_rst_n(rst_n), .leds(leds),
        .sys_clk_gt(gt[2]), .sys_clk(clk[2]), .sys_rst_n_c(rstc[2]),
        .led_0(led2[0]), .led_1(led2[1]), .led_2(led2[2]), .led_3(led2[3]));

    task automatic test_reset();
        #1;
        checks++;
        if (clk !== 3'b000) begin
            errors++;
            $display("FAIL reset_sys_clk: got %b expected 000", clk);
        end
        checks++;
        if (gt !== 3'b000) begin
            errors++;
            $display("FAIL reset_gt_low: got %b expected 000", gt);
        end
        @(posedge p); #1;
        checks++;
        if (gt !== 3'b111) begin
            errors++;
            $display("FAIL reset_gt_follows: got %b expected 111", gt);
        end
        checks++;
        if (clk !== 3'b000) begin
            errors++;
            $display("FAIL reset_forces_sys_clk: got %b expected 000", clk);
        end
        // release while the clock is high: mode 00 resumes immediately
        rst = 1'b0;
        #1;
        checks++;
        if (clk[0] !== 1'b1) begin
            errors++;
            $display("FAIL release_mode00_immediate: got %b expected 1", clk[0]);
        end
    endtask

    task automatic test_mode00();
        repeat (8) begin
            @(posedge p); #1;
            checks++;
            if (gt[0] !== 1'b1 || clk[0] !== 1'b1) begin
                errors++;
                $display("FAIL mode00_high: gt=%b clk=%b expected 1 1", gt[0], clk[0]);
            end
            @(negedge p); #1;
            checks++;
            if (gt[0] !== 1'b0 || clk[0] !== 1'b0) begin
                errors++;
                $display("FAIL mode00_low: gt=%b clk=%b expected 0 0", gt[0], clk[0]);
            end
        end
    endtask

    task automatic test_mode01();
        rst = 1'b1;
        @(negedge p); #1;
        checks++;
        if (clk[1] !== 1'b0) begin
            errors++;
            $display("FAIL mode01_in_reset: got %b expected 0", clk[1]);
        end
        rst = 1'b0;
        div = 1'b0;
        repeat (6) begin
            @(posedge p); #1;
            div = ~div;
            checks++;
            if (clk[1] !== div) begin
                errors++;
                $display("FAIL mode01_rise: got %b expected %b", clk[1], div);
            end
            checks++;
            if (clk[2] !== 1'b0) begin
                errors++;
                $display("FAIL mode10_const: got %b expected 0", clk[2]);
            end
            #5;
            checks++;
            if (clk[1] !== div) begin
                errors++;
                $display("FAIL mode01_fall_hold: got %b expected %b", clk[1], div);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge p); #1;
        div = ~div;
        checks++;
        if (clk[1] !== 1'b1 || div !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_high: got %b expected 1", clk[1]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (clk[1] !== 1'b0 || clk[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_drop: got clk1=%b clk0=%b expected 0 0", clk[1], clk[0]);
        end
        checks++;
        if (gt[0] !== 1'b1) begin
            errors++;
            $display("FAIL gt_ignores_reset: got %b expected 1", gt[0]);
        end
        @(negedge p); #1;
        rst = 1'b0;
        div = 1'b0;
        #1;
        checks++;
        if (clk[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_wait: got %b expected 0", clk[1]);
        end
        @(posedge p); #1;
        div = ~div;
        checks++;
        if (clk[1] !== div || clk[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: got clk1=%b clk0=%b expected %b 1", clk[1], clk[0], div);
        end
    endtask

    task automatic test_ceb();
        @(negedge p); #1;
        ceb = 1'b1;
        repeat (10) begin
            @(posedge p); #1;
            checks++;
            if (gt !== 3'b000 || clk[0] !== 1'b0) begin
                errors++;
                $display("FAIL ceb_gated: gt=%b clk0=%b expected 000 0", gt, clk[0]);
            end
            checks++;
            if (clk[1] !== div) begin
                errors++;
                $display("FAIL ceb_div_hold: got %b expected %b", clk[1], div);
            end
        end
        @(negedge p); #1;
        ceb = 1'b0;
        #1;
        checks++;
        if (gt[0] !== 1'b0 || clk[1] !== div) begin
            errors++;
            $display("FAIL ceb_release_no_glitch: gt=%b clk1=%b expected 0 %b", gt[0], clk[1], div);
        end
        @(posedge p); #1;
        div = ~div;
        checks++;
        if (gt[0] !== 1'b1 || clk[0] !== 1'b1 || clk[1] !== div) begin
            errors++;
            $display("FAIL ceb_resume: gt=%b clk0=%b clk1=%b expected 1 1 %b", gt[0], clk[0], clk[1], div);
        end
    endtask

    task automatic test_hold();
        @(negedge p); #1;
        run_clk = 1'b0;
        #10;
        p = 1'b1; n = 1'b0; #1;
        checks++;
        if (gt[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_drive_high: got %b expected 1", gt[0]);
        end
        n = 1'b1; #1;
        checks++;
        if (gt[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_both_high: got %b expected 1", gt[0]);
        end
        p = 1'b0; n = 1'b0; #1;
        checks++;
        if (gt[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_both_low: got %b expected 1", gt[0]);
        end
        n = 1'b1; #1;
        checks++;
        if (gt[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_drive_low: got %b expected 0", gt[0]);
        end
        run_clk = 1'b1;
    endtask

    task automatic test_passthrough();
        rst_n = 1'b0;
        leds = 4'b1010;
        #1;
        checks++;
        if (rstc !== 3'b000) begin
            errors++;
            $display("FAIL rst_n_low: got %b expected 000", rstc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rstc !== 3'b111) begin
            errors++;
            $display("FAIL rst_n_high: got %b expected 111", rstc);
        end
        checks++;
        if (led0 !== 4'b1010 || led1 !== 4'b1010 || led2 !== 4'b1010) begin
            errors++;
            $display("FAIL leds_1010: got %b %b %b expected 1010", led0, led1, led2);
        end
        rst = 1'b1;
        ceb = 1'b1;
        leds = 4'b0101;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led0 !== 4'b0101 || rstc[0] !== 1'b0) begin
            errors++;
            $display("FAIL pass_in_reset: leds=%b rstc=%b expected 0101 0", led0, rstc[0]);
        end
        rst = 1'b0;
        ceb = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        ceb   = 1'b0;
        rst_n = 1'b0;
        leds  = 4'b0000;
        test_reset();
        test_mode00();
        test_mode01();
        test_reset_mid();
        test_ceb();
        test_hold();
        test_passthrough();
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
